// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one palette RAM among sprite requesters.
// Two-stage lookup pipeline with backpressure and a config write port.
module palette_lookup_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_PAL = 8,
  parameter int PAL_W   = $clog2(NUM_PAL),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*PAL_W-1:0] i_req_pal,
  input  logic [NUM_REQ*4-1:0]     i_req_idx,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic                     i_cfg_we,
  input  logic [PAL_W-1:0]         i_cfg_pal,
  input  logic [3:0]               i_cfg_idx,
  input  logic [23:0]              i_cfg_color,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [23:0]              o_rsp_color,
  output logic                     o_rsp_transparent,
  input  logic                     i_rsp_ready
);

  localparam int DEPTH = NUM_PAL * 16;

  logic [23:0]      mem [DEPTH];
  logic             advance;
  logic [ID_W-1:0]  rr;
  logic [NUM_REQ-1:0] grant;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [PAL_W-1:0] gnt_pal;
  logic [3:0]       gnt_idx;
  int unsigned      slot;

  logic             a_vld;
  logic [ID_W-1:0]  a_id;
  logic [PAL_W-1:0] a_pal;
  logic [3:0]       a_idx;
  logic [23:0]      rd_data;

  // Config writes always land; they stall the pipeline for that cycle.
  assign advance = !i_rst && !i_cfg_we && (!o_rsp_valid || i_rsp_ready);

  // Palette RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we)
      mem[{i_cfg_pal, i_cfg_idx}] <= i_cfg_color;
  end

  // Round-robin search for the first valid requester starting at rr.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    slot    = 0;
    if (advance) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot = (int'(rr) + i) % NUM_REQ;
        if (!gnt_any && i_req_valid[slot]) begin
          gnt_any     = 1'b1;
          grant[slot] = 1'b1;
          gnt_id      = ID_W'(slot);
        end
      end
    end
  end

  assign o_req_ready = grant;
  assign gnt_pal = i_req_pal[int'(gnt_id)*PAL_W +: PAL_W];
  assign gnt_idx = i_req_idx[int'(gnt_id)*4 +: 4];
  assign rd_data = mem[{a_pal, a_idx}];

  // Pointer moves past the winner so every requester gets a turn.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      rr <= '0;
    else if (gnt_any)
      rr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
  end

  // Stage A captures the granted request (or a bubble).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_vld <= 1'b0;
      a_id  <= '0;
      a_pal <= '0;
      a_idx <= '0;
    end else if (advance) begin
      a_vld <= gnt_any;
      a_id  <= gnt_id;
      a_pal <= gnt_pal;
      a_idx <= gnt_idx;
    end
  end

  // Stage B reads the RAM; index 0 is forced transparent black.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid       <= 1'b0;
      o_rsp_id          <= '0;
      o_rsp_color       <= '0;
      o_rsp_transparent <= 1'b0;
    end else if (advance) begin
      o_rsp_valid       <= a_vld;
      o_rsp_id          <= a_id;
      o_rsp_transparent <= (a_idx == 4'd0);
      o_rsp_color       <= (a_idx == 4'd0) ? 24'h000000 : rd_data;
    end
  end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed scenarios then random
// traffic, checked cycle by cycle against a reference model.
module tb_palette_lookup_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_PAL = 8;
  localparam int PAL_W   = 3;
  localparam int ID_W    = 2;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ*PAL_W-1:0] i_req_pal;
  logic [NUM_REQ*4-1:0]     i_req_idx;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic                     i_cfg_we;
  logic [PAL_W-1:0]         i_cfg_pal;
  logic [3:0]               i_cfg_idx;
  logic [23:0]              i_cfg_color;
  logic                     o_rsp_valid;
  logic [ID_W-1:0]          o_rsp_id;
  logic [23:0]              o_rsp_color;
  logic                     o_rsp_transparent;
  logic                     i_rsp_ready;

  palette_lookup_arbiter #(
    .NUM_REQ(NUM_REQ),
    .NUM_PAL(NUM_PAL)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .i_req_pal(i_req_pal),
    .i_req_idx(i_req_idx),
    .o_req_ready(o_req_ready),
    .i_cfg_we(i_cfg_we),
    .i_cfg_pal(i_cfg_pal),
    .i_cfg_idx(i_cfg_idx),
    .i_cfg_color(i_cfg_color),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_id(o_rsp_id),
    .o_rsp_color(o_rsp_color),
    .o_rsp_transparent(o_rsp_transparent),
    .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: palette contents, pointer, two pipeline slots.
  logic [23:0] m_mem [NUM_PAL*16];
  int          m_rr;
  bit          ma_vld;
  int          ma_id, ma_pal, ma_idx;
  bit          mb_vld;
  int          mb_id;
  logic [23:0] mb_col;
  bit          mb_tr;

  // Requesters' pending lookups.
  bit pend [NUM_REQ];
  int p_pal [NUM_REQ];
  int p_idx [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_valid[k] = pend[k];
      i_req_pal[k*PAL_W +: PAL_W] = PAL_W'(p_pal[k]);
      i_req_idx[k*4 +: 4] = 4'(p_idx[k]);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit adv;
    int g;
    int k;
    logic [NUM_REQ-1:0] expg;
    apply();
    @(negedge i_clk);
    adv = !i_rst && !i_cfg_we && (!mb_vld || i_rsp_ready);
    g = -1;
    if (adv)
      for (int i = 0; i < NUM_REQ; i++) begin
        k = (m_rr + i) % NUM_REQ;
        if (g < 0 && pend[k]) g = k;
      end
    expg = (g >= 0) ? NUM_REQ'(1 << g) : '0;
    chk("ready", 32'(o_req_ready), 32'(expg));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(mb_vld));
    if (mb_vld) begin
      chk("rsp_id", 32'(o_rsp_id), 32'(mb_id));
      chk("rsp_color", 32'(o_rsp_color), 32'(mb_col));
      chk("rsp_transp", 32'(o_rsp_transparent), 32'(mb_tr));
    end
    @(posedge i_clk);
    if (i_rst) begin
      ma_vld = 0; mb_vld = 0; mb_id = 0; mb_col = 0; mb_tr = 0;
      m_rr = 0;
    end else if (adv) begin
      mb_vld = ma_vld;
      mb_id  = ma_id;
      mb_tr  = (ma_idx == 0);
      mb_col = (ma_idx == 0) ? 24'h0 : m_mem[ma_pal*16 + ma_idx];
      ma_vld = (g >= 0);
      if (g >= 0) begin
        ma_id = g; ma_pal = p_pal[g]; ma_idx = p_idx[g];
        m_rr = (g + 1) % NUM_REQ;
        pend[g] = 0;
      end
    end
    if (i_cfg_we)
      m_mem[int'(i_cfg_pal)*16 + int'(i_cfg_idx)] = i_cfg_color;
    #1;
  endtask

  task automatic wr(input int p, input int i, input logic [23:0] c);
    i_cfg_we = 1; i_cfg_pal = PAL_W'(p); i_cfg_idx = 4'(i);
    i_cfg_color = c;
    cycle();
    i_cfg_we = 0;
  endtask

  task automatic req(input int k, input int p, input int i);
    pend[k] = 1; p_pal[k] = p; p_idx[k] = i;
  endtask

  task automatic drain();
    for (int k = 0; k < NUM_REQ; k++) pend[k] = 0;
    i_rsp_ready = 1;
    repeat (3) cycle();
  endtask

  initial begin
    i_rst = 1; i_cfg_we = 0; i_cfg_pal = '0; i_cfg_idx = '0;
    i_cfg_color = '0; i_rsp_ready = 1;
    i_req_valid = '0; i_req_pal = '0; i_req_idx = '0;
    m_rr = 0; ma_vld = 0; ma_id = 0; ma_pal = 0; ma_idx = 0;
    mb_vld = 0; mb_id = 0; mb_col = 0; mb_tr = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pend[k] = 0; p_pal[k] = 0; p_idx[k] = 0;
    end
    for (int a = 0; a < NUM_PAL*16; a++) m_mem[a] = 'x;

    // Reset with a request pending: no grant while in reset.
    req(2, 1, 1);
    repeat (2) cycle();
    chk("reset_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_color", 32'(o_rsp_color), 32'd0);
    chk("reset_id", 32'(o_rsp_id), 32'd0);
    chk("reset_transp", 32'(o_rsp_transparent), 32'd0);
    pend[2] = 0;
    i_rst = 0;

    // Fill every palette entry so later random lookups are defined.
    for (int p = 0; p < NUM_PAL; p++)
      for (int i = 0; i < 16; i++)
        wr(p, i, 24'($urandom));

    // Basic lookup, latency two cycles after grant.
    wr(2, 5, 24'hff7f00);
    req(1, 2, 5);
    cycle();
    cycle();
    chk("basic_valid", 32'(o_rsp_valid), 32'd1);
    chk("basic_id", 32'(o_rsp_id), 32'd1);
    chk("basic_color", 32'(o_rsp_color), 32'hff7f00);
    chk("basic_transp", 32'(o_rsp_transparent), 32'd0);
    drain();

    // Index 0 is transparent regardless of RAM contents.
    wr(3, 0, 24'h123456);
    req(0, 3, 0);
    cycle();
    cycle();
    chk("transp_color", 32'(o_rsp_color), 32'h0);
    chk("transp_flag", 32'(o_rsp_transparent), 32'd1);
    drain();

    // All requesters continuously valid: round-robin rotation.
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!pend[k]) req(k, (c + k) % NUM_PAL, (c * 3 + k) % 16);
      cycle();
    end

    // Backpressure for five cycles, then release.
    i_rsp_ready = 0;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!pend[k]) req(k, k, c + 1);
      cycle();
    end
    i_rsp_ready = 1;
    repeat (6) cycle();
    drain();

    // Rewrite an entry while its lookup waits in stage A.
    wr(1, 4, 24'h90f64f);
    req(2, 1, 4);
    cycle();
    wr(1, 4, 24'hfe0000);
    chk("wr_stall_valid", 32'(o_rsp_valid), 32'd0);
    cycle();
    chk("wr_late_valid", 32'(o_rsp_valid), 32'd1);
    chk("wr_new_color", 32'(o_rsp_color), 32'hfe0000);
    drain();

    // Reset with two lookups in flight; RAM survives.
    for (int k = 0; k < NUM_REQ; k++) req(k, 2, 5);
    cycle();
    cycle();
    i_rst = 1;
    cycle();
    chk("rst_drop_valid", 32'(o_rsp_valid), 32'd0);
    i_rst = 0;
    repeat (6) cycle();
    drain();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!pend[k] && $urandom_range(0, 99) < 45)
          req(k, $urandom_range(0, NUM_PAL-1), $urandom_range(0, 15));
      i_rsp_ready = ($urandom_range(0, 99) < 75);
      i_rst = ($urandom_range(0, 199) == 0);
      i_cfg_we = ($urandom_range(0, 99) < 10);
      i_cfg_pal = PAL_W'($urandom_range(0, NUM_PAL-1));
      i_cfg_idx = 4'($urandom_range(0, 15));
      i_cfg_color = 24'($urandom);
      cycle();
    end
    i_rst = 0; i_cfg_we = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_lookup_arbiter.md
# palette_lookup_arbiter

Shares one palette memory between several sprite render requesters. Each requester asks for a 24-bit RGB color by palette number and 4-bit color index. The block holds NUM_PAL palettes of 16 entries each in an internal synchronous RAM that is loaded through a configuration write port. It grants one lookup per cycle with round-robin arbitration and returns the color through a 2-stage pipeline with backpressure. Index 0 of every palette means transparent. The block sits between the sprite fetch units and the layer compositor in the render interface.

## Interface
- NUM_REQ, 4, number of lookup requesters (2..8)
- NUM_PAL, 8, number of 16-entry palettes held
- PAL_W, $clog2(NUM_PAL), palette select width
- ID_W, $clog2(NUM_REQ), requester id width
- i_clk  in  1  single clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_REQ  per-requester lookup request
- i_req_pal  in  NUM_REQ*PAL_W  palette select; requester k uses bits [k*PAL_W +: PAL_W]
- i_req_idx  in  NUM_REQ*4  color index; requester k uses bits [k*4 +: 4]
- o_req_ready  out  NUM_REQ  one-hot grant; a lookup is accepted when valid and ready are both 1
- i_cfg_we  in  1  palette write strobe, always accepted
- i_cfg_pal  in  PAL_W  palette to write
- i_cfg_idx  in  4  entry to write
- i_cfg_color  in  24  RGB888 value to write
- o_rsp_valid  out  1  response available
- o_rsp_id  out  ID_W  requester that issued the lookup
- o_rsp_color  out  24  RGB888 result; 24'h000000 when transparent
- o_rsp_transparent  out  1  set when the looked-up index was 0
- i_rsp_ready  in  1  consumer accepts the response

## Operation
- Storage: NUM_PAL*16 x 24 RAM at address {pal, idx}. Reset does not clear it, and contents are undefined until written. Index 0 never reads the RAM value: it is forced to transparent with color 24'h000000.
- advance = !i_rst && !i_cfg_we && (!o_rsp_valid || i_rsp_ready).
- Write priority: in a cycle with i_cfg_we=1, the RAM is written, o_req_ready is all 0, and both pipeline stages hold.
- Arbitration: round-robin pointer rr (0..NUM_REQ-1).
  - When advance is 1, grant the first valid requester starting at rr and wrapping.
  - o_req_ready is that one-hot grant. It is 0 when advance is 0 or no request is valid.
  - On a grant to k, rr becomes (k+1) mod NUM_REQ. Otherwise rr holds.
- Stage A (registered on advance): a_vld = any grant, plus the granted id, pal and idx. A cycle with advance=1 and no grant loads a bubble (a_vld=0).
- Stage B (registered on advance): issue the synchronous RAM read of stage A's address. Then o_rsp_valid = a_vld, o_rsp_id = A.id, o_rsp_transparent = (A.idx==0), o_rsp_color = (A.idx==0) ? 0 : RAM data.
- Response handshake:
  - Transfer happens when o_rsp_valid && i_rsp_ready.
  - While o_rsp_valid=1 and i_rsp_ready=0, all outputs hold stable and no grant is issued.
- Coherence: a lookup returns the RAM value after every write accepted before its stage-B load cycle. This includes writes accepted while the lookup waits in stage A.
- Requests are not queued. A requester holds valid and its inputs until granted; the block samples the inputs only in the grant cycle.

## Timing
- Reset values: o_rsp_valid=0, o_rsp_id=0, o_rsp_color=0, o_rsp_transparent=0, a_vld=0, rr=0. o_req_ready=0 during any cycle with i_rst=1.
- Reset mid-operation: in-flight lookups are dropped with no response. RAM contents are kept.
- Latency: grant at edge t gives o_rsp_valid=1 after edge t+1, i.e. the response is visible in cycle t+2 with no stalls.
- Throughput: 1 lookup per cycle when there are no writes and i_rsp_ready=1.
- Each i_cfg_we cycle inserts exactly one stall cycle into both stages.
- Simultaneous write and pending request: the write wins, and the request is granted on the next advance cycle.
- A write to the address a lookup is about to read, in the cycle before stage B loads: the lookup returns the new value.
- rr wraps from NUM_REQ-1 to 0.

## Test plan
- Reset, write 16'h... palette 2 idx 5 = 24'hff7f00, then requester 1 looks up (2,5) → grant in cycle t; o_rsp_valid, id=1, color=24'hff7f00, transparent=0 in cycle t+2.
- All 4 requesters hold valid continuously, i_rsp_ready=1 → grant order 0,1,2,3,0,…; one response per cycle with matching ids.
- Lookup (3,0) after writing palette 3 idx 0 = 24'h123456 → color=24'h000000, transparent=1.
- i_rsp_ready=0 for 5 cycles with valid requests → o_req_ready=0 and outputs frozen; after release, responses resume in order with none lost or duplicated.
- i_cfg_we pulsed for 1 cycle rewriting (1,4) from 24'h90f64f to 24'hfe0000 while a (1,4) lookup sits in stage A → response is 24'hfe0000, and the lookup completes exactly one cycle later than it would without the write.
- i_rst asserted with 2 lookups in flight → o_rsp_valid=0 next cycle, no stale responses afterwards, rr=0, previously written RAM entries still read back correctly.
